// File: rtl/vectored_int_pkg.sv
// Shared encodings for the vectored interrupt controller: FSM states,
// arbitration mode constants and a constant-foldable clog2.
package vectored_int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam bit RR_FIXED = 1'b0;
  localparam bit RR_ROUND = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/vint_arbiter.sv
// Combinational NUM_CH-way picker: lowest set index in fixed mode, first set
// index at or above ptr (with wrap) in round-robin mode.
module vint_arbiter
  import vectored_int_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              mode,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid
);

  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] cand;

  // Scan downward from the farthest candidate so the nearest hit writes last.
  always_comb begin
    base        = (mode == RR_ROUND) ? ptr : '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(base) + k) % NUM_CH);
      if (req[cand]) begin
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vectored_int_ctrl.sv
// Vectored interrupt controller: latches done edges, arbitrates unmasked pending
// channels and holds one vector on int_addr through a two-phase int_ack handshake.
module vectored_int_ctrl
  import vectored_int_pkg::*;
#(
  parameter int              NUM_CH     = 4,
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(32'hFFFF_FFFC),
  parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(1),
  parameter bit              RR_MODE    = RR_FIXED,
  localparam int             IDX_W      = clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] done,
  input  logic [NUM_CH-1:0] int_mask,
  input  logic              int_ack,
  input  logic              ovr_clr,
  output logic              irq,
  output logic [ADDR_W-1:0] int_addr,
  output logic [IDX_W-1:0]  int_id,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overrun
);

  state_e            state_q;
  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] overrun_q, overrun_d;
  logic              irq_q;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  id_q;
  logic [IDX_W-1:0]  ptr_q;

  logic [NUM_CH-1:0] ev;
  logic [NUM_CH-1:0] clr;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;

  vint_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req         (pending_q & ~int_mask),
    .ptr         (ptr_q),
    .mode        (RR_MODE),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // A new edge on a channel being acknowledged re-arms it rather than overrunning.
  always_comb begin
    ev  = done & ~done_q;
    clr = '0;
    if (state_q == ST_REQ && int_ack) clr[id_q] = 1'b1;
    pending_d = (pending_q & ~clr) | ev;
    overrun_d = (ovr_clr ? '0 : overrun_q) | (ev & pending_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      done_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      irq_q     <= 1'b0;
      addr_q    <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
    end else begin
      done_q    <= done;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            state_q <= ST_REQ;
            irq_q   <= 1'b1;
            id_q    <= grant_idx;
            addr_q  <= VEC_BASE + ADDR_W'(grant_idx) * VEC_STRIDE;
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            state_q <= ST_ACK;
            irq_q   <= 1'b0;
            addr_q  <= '0;
            if (RR_MODE == RR_ROUND)
              ptr_q <= (id_q == IDX_W'(NUM_CH - 1)) ? '0 : id_q + 1'b1;
          end
        end
        ST_ACK: begin
          if (!int_ack) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign irq      = irq_q;
  assign int_addr = addr_q;
  assign int_id   = id_q;
  assign pending  = pending_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Bench for vectored_int_ctrl: cycle table on a fixed-priority instance, then
// round-robin serve-order sequences on a second instance sharing the inputs.
module tb_vectored_int_ctrl;

  localparam logic [31:0] VB = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst;
  logic [3:0]  done;
  logic [3:0]  int_mask;
  logic        int_ack;
  logic        ovr_clr;

  logic        fx_irq, rr_irq;
  logic [31:0] fx_addr, rr_addr;
  logic [1:0]  fx_id, rr_id;
  logic [3:0]  fx_pend, rr_pend, fx_ovr, rr_ovr;

  vectored_int_ctrl #(.NUM_CH(4), .ADDR_W(32), .VEC_BASE(32'hFFFF_FFFC),
                      .VEC_STRIDE(32'd1), .RR_MODE(1'b0)) dut_fx (
    .clk(clk), .rst(rst), .done(done), .int_mask(int_mask), .int_ack(int_ack),
    .ovr_clr(ovr_clr), .irq(fx_irq), .int_addr(fx_addr), .int_id(fx_id),
    .pending(fx_pend), .overrun(fx_ovr));

  vectored_int_ctrl #(.NUM_CH(4), .ADDR_W(32), .VEC_BASE(32'hFFFF_FFFC),
                      .VEC_STRIDE(32'd1), .RR_MODE(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .done(done), .int_mask(int_mask), .int_ack(int_ack),
    .ovr_clr(ovr_clr), .irq(rr_irq), .int_addr(rr_addr), .int_id(rr_id),
    .pending(rr_pend), .overrun(rr_ovr));

  typedef struct packed {
    logic        irq;
    logic [31:0] addr;
    logic [1:0]  id;
    logic [3:0]  pend;
    logic [3:0]  ovr;
  } obs_t;

  typedef struct {
    logic       rst;
    logic [3:0] done;
    logic [3:0] mask;
    logic       ack;
    logic       oclr;
    obs_t       exp;
  } vec_t;

  vec_t       tbl[$];
  obs_t       sb[$];
  logic [1:0] exp_rr[$];
  logic [1:0] exp_fx[$];
  int         checks = 0;
  int         errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic r, input logic [3:0] d, input logic [3:0] m,
                     input logic a, input logic o, input logic i,
                     input logic [31:0] ad, input logic [1:0] id,
                     input logic [3:0] p, input logic [3:0] ov);
    vec_t v;
    v.rst = r; v.done = d; v.mask = m; v.ack = a; v.oclr = o;
    v.exp = {i, ad, id, p, ov};
    tbl.push_back(v);
  endtask

  task automatic wait_irq(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (rr_irq) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Serves one request on both instances; done_on_ack is driven during the ack cycle.
  task automatic serve(input string tag, input logic [3:0] done_on_ack);
    bit         ok;
    logic [1:0] er, ef;
    wait_irq(ok);
    er = exp_rr.pop_front();
    ef = exp_fx.pop_front();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout: irq=%0b, need 1", tag, rr_irq);
      return;
    end
    checks++;
    if (rr_id !== er || rr_addr !== VB + {30'b0, er}) begin
      errors++;
      $display("FAIL %s rr: id=%0d addr=%h, need id=%0d addr=%h",
               tag, rr_id, rr_addr, er, VB + {30'b0, er});
    end
    checks++;
    if (fx_irq !== 1'b1 || fx_id !== ef) begin
      errors++;
      $display("FAIL %s fx: irq=%0b id=%0d, need irq=1 id=%0d", tag, fx_irq, fx_id, ef);
    end
    int_ack = 1'b1;
    done    = done_on_ack;
    @(posedge clk); #1;
    done = 4'b0000;
    checks++;
    if (rr_irq !== 1'b0 || fx_irq !== 1'b0) begin
      errors++;
      $display("FAIL %s ack drop: rr_irq=%0b fx_irq=%0b, need 0 0", tag, rr_irq, fx_irq);
    end
    int_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    obs_t got, e;
    rst = 1'b1; done = '0; int_mask = '0; int_ack = 1'b0; ovr_clr = 1'b0;

    //  rst done     mask     ack  oclr irq addr        id    pend     ovr
    add(1, 4'b0000, 4'b0000, 0, 0,  0, 32'h0,      2'd0, 4'b0000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0,  0, 32'h0,      2'd0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0,  0, 32'h0,      2'd0, 4'b0000, 4'b0000);
    add(0, 4'b0001, 4'b0000, 0, 0,  0, 32'h0,      2'd0, 4'b0001, 4'b0000);
    add(0, 4'b0001, 4'b0000, 0, 0,  1, VB,         2'd0, 4'b0001, 4'b0000);
    add(0, 4'b0000, 4'b0000, 1, 0,  0, 32'h0,      2'd0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 1, 0,  0, 32'h0,      2'd0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0,  0, 32'h0,      2'd0, 4'b0000, 4'b0000);
    add(0, 4'b0100, 4'b0000, 0, 0,  0, 32'h0,      2'd0, 4'b0100, 4'b0000);
    add(0, 4'b0110, 4'b0000, 0, 0,  1, VB + 32'd2, 2'd2, 4'b0110, 4'b0000);
    add(0, 4'b0110, 4'b0000, 0, 0,  1, VB + 32'd2, 2'd2, 4'b0110, 4'b0000);
    add(0, 4'b0000, 4'b0000, 1, 0,  0, 32'h0,      2'd2, 4'b0010, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0,  0, 32'h0,      2'd2, 4'b0010, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0,  1, VB + 32'd1, 2'd1, 4'b0010, 4'b0000);
    add(0, 4'b0000, 4'b0000, 1, 0,  0, 32'h0,      2'd1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0,  0, 32'h0,      2'd1, 4'b0000, 4'b0000);
    add(0, 4'b1001, 4'b0001, 0, 0,  0, 32'h0,      2'd1, 4'b1001, 4'b0000);
    add(0, 4'b1001, 4'b0001, 0, 0,  1, VB + 32'd3, 2'd3, 4'b1001, 4'b0000);
    add(0, 4'b0000, 4'b0001, 1, 0,  0, 32'h0,      2'd3, 4'b0001, 4'b0000);
    add(0, 4'b0000, 4'b0001, 0, 0,  0, 32'h0,      2'd3, 4'b0001, 4'b0000);
    add(0, 4'b0000, 4'b0001, 0, 0,  0, 32'h0,      2'd3, 4'b0001, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0,  1, VB,         2'd0, 4'b0001, 4'b0000);
    add(0, 4'b0000, 4'b0000, 1, 0,  0, 32'h0,      2'd0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0,  0, 32'h0,      2'd0, 4'b0000, 4'b0000);
    add(0, 4'b0010, 4'b0000, 0, 0,  0, 32'h0,      2'd0, 4'b0010, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0,  1, VB + 32'd1, 2'd1, 4'b0010, 4'b0000);
    add(0, 4'b0010, 4'b0000, 0, 0,  1, VB + 32'd1, 2'd1, 4'b0010, 4'b0010);
    add(0, 4'b0010, 4'b0000, 1, 0,  0, 32'h0,      2'd1, 4'b0000, 4'b0010);
    add(0, 4'b0000, 4'b0000, 0, 0,  0, 32'h0,      2'd1, 4'b0000, 4'b0010);
    add(0, 4'b0000, 4'b0000, 0, 1,  0, 32'h0,      2'd1, 4'b0000, 4'b0000);
    add(0, 4'b0010, 4'b0000, 0, 0,  0, 32'h0,      2'd1, 4'b0010, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0,  1, VB + 32'd1, 2'd1, 4'b0010, 4'b0000);
    add(0, 4'b0010, 4'b0000, 1, 0,  0, 32'h0,      2'd1, 4'b0010, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0,  0, 32'h0,      2'd1, 4'b0010, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0,  1, VB + 32'd1, 2'd1, 4'b0010, 4'b0000);
    add(1, 4'b0000, 4'b0000, 1, 0,  0, 32'h0,      2'd0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 1, 0,  0, 32'h0,      2'd0, 4'b0000, 4'b0000);
    add(0, 4'b0001, 4'b0000, 1, 0,  0, 32'h0,      2'd0, 4'b0001, 4'b0000);
    add(0, 4'b0001, 4'b0000, 1, 0,  1, VB,         2'd0, 4'b0001, 4'b0000);
    add(0, 4'b0000, 4'b0000, 1, 0,  0, 32'h0,      2'd0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0,  0, 32'h0,      2'd0, 4'b0000, 4'b0000);
    add(0, 4'b0100, 4'b0000, 0, 0,  0, 32'h0,      2'd0, 4'b0100, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0,  1, VB + 32'd2, 2'd2, 4'b0100, 4'b0000);
    add(0, 4'b0100, 4'b0000, 0, 1,  1, VB + 32'd2, 2'd2, 4'b0100, 4'b0100);
    add(0, 4'b0000, 4'b0000, 1, 0,  0, 32'h0,      2'd2, 4'b0000, 4'b0100);
    add(0, 4'b0000, 4'b0000, 0, 1,  0, 32'h0,      2'd2, 4'b0000, 4'b0000);

    for (int n = 0; n < tbl.size(); n++) begin
      rst      = tbl[n].rst;
      done     = tbl[n].done;
      int_mask = tbl[n].mask;
      int_ack  = tbl[n].ack;
      ovr_clr  = tbl[n].oclr;
      sb.push_back(tbl[n].exp);
      @(posedge clk); #1;
      got = {fx_irq, fx_addr, fx_id, fx_pend, fx_ovr};
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL row%0d: irq=%0b addr=%h id=%0d pend=%b ovr=%b, need irq=%0b addr=%h id=%0d pend=%b ovr=%b",
                 n, got.irq, got.addr, got.id, got.pend, got.ovr,
                 e.irq, e.addr, e.id, e.pend, e.ovr);
      end
    end

    // Round-robin: fresh reset, all four pending at once.
    rst = 1'b1; done = '0; int_mask = '0; int_ack = 1'b0; ovr_clr = 1'b0;
    @(posedge clk); #1;
    rst  = 1'b0;
    done = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp_rr.push_back(2'(k));
      exp_fx.push_back(2'(k));
    end
    @(posedge clk); #1;
    done = 4'b0000;
    for (int k = 0; k < 4; k++) serve($sformatf("rr_round1_%0d", k), 4'b0000);

    // Re-raise: pointer wrapped to 0, then ch0 re-fires while being acknowledged.
    done = 4'b1111;
    exp_rr.push_back(2'd0);
    exp_fx.push_back(2'd0);
    @(posedge clk); #1;
    done = 4'b0000;
    exp_rr.push_back(2'd1);
    exp_fx.push_back(2'd0);
    serve("rr_wrap", 4'b0001);
    serve("rr_vs_fixed", 4'b0000);

    checks++;
    if (fx_pend !== 4'b1110 || rr_pend !== 4'b1101) begin
      errors++;
      $display("FAIL rr_pending: fx=%b rr=%b, need fx=1110 rr=1101", fx_pend, rr_pend);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
